// File: rtl/lc_mem_arbiter_if.sv
// Bus bundle for lc_mem_arbiter: two requester ports, the memory-controller port and
// the arbiter status outputs (GRANT, TIMEOUT_ERR).
//   slave  : arbiter view (requester/memory inputs in, ACK/RD_DATA/MEM_* out)
//   master : environment view (requesters and memory controller), directions reversed
interface lc_mem_arbiter_if #(
  parameter int unsigned LC_MEM_DATA_WIDTH = 32,
  parameter int unsigned LC_MEM_ADDR_WIDTH = 32
);
  localparam int unsigned AW = LC_MEM_ADDR_WIDTH - 2;

  // Requester side
  logic                         M0_REQ,     M1_REQ;
  logic                         M0_WRITE,   M1_WRITE;
  logic [AW-1:0]                M0_ADDR,    M1_ADDR;
  logic [LC_MEM_DATA_WIDTH-1:0] M0_WR_DATA, M1_WR_DATA;
  logic                         M0_PEND,    M1_PEND;
  logic                         M0_ACK,     M1_ACK;
  logic [LC_MEM_DATA_WIDTH-1:0] M0_RD_DATA, M1_RD_DATA;

  // Memory-controller side
  logic                         MEM_REQ_OUT;
  logic                         MEM_WRITE;
  logic [AW-1:0]                MEM_ADDR;
  logic [LC_MEM_DATA_WIDTH-1:0] MEM_WR_DATA;
  logic                         MEM_ACK_IN;
  logic [LC_MEM_DATA_WIDTH-1:0] MEM_RD_DATA;

  // Status
  logic [1:0]                   GRANT;
  logic                         TIMEOUT_ERR;

  modport slave (
    input  M0_REQ, M1_REQ, M0_WRITE, M1_WRITE, M0_ADDR, M1_ADDR,
    input  M0_WR_DATA, M1_WR_DATA, M0_PEND, M1_PEND,
    output M0_ACK, M1_ACK, M0_RD_DATA, M1_RD_DATA,
    output MEM_REQ_OUT, MEM_WRITE, MEM_ADDR, MEM_WR_DATA,
    input  MEM_ACK_IN, MEM_RD_DATA,
    output GRANT, TIMEOUT_ERR
  );

  modport master (
    output M0_REQ, M1_REQ, M0_WRITE, M1_WRITE, M0_ADDR, M1_ADDR,
    output M0_WR_DATA, M1_WR_DATA, M0_PEND, M1_PEND,
    input  M0_ACK, M1_ACK, M0_RD_DATA, M1_RD_DATA,
    input  MEM_REQ_OUT, MEM_WRITE, MEM_ADDR, MEM_WR_DATA,
    output MEM_ACK_IN, MEM_RD_DATA,
    input  GRANT, TIMEOUT_ERR
  );
endinterface

// File: rtl/lc_mem_arbiter.sv
// Two-requester round-robin memory arbiter with burst lock and four-phase handshakes on
// both the requester and memory-controller sides.
//
// Ports:
//   CLK   : sole clock, rising edge
//   RESET : synchronous, active-high reset
//   bus   : lc_mem_arbiter_if.slave -- M0/M1 request ports, memory-controller port,
//           GRANT (one-hot owner, 00 when idle) and TIMEOUT_ERR (sticky)
//
// Optional feature: define ARB_TIMEOUT_EN to enable the memory-ack timeout. Without it the
// arbiter waits for MEM_ACK_IN indefinitely and TIMEOUT_ERR is tied low.
module lc_mem_arbiter #(
  parameter int unsigned LC_MEM_DATA_WIDTH = 32,
  parameter int unsigned LC_MEM_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input logic              CLK,
  input logic              RESET,
  lc_mem_arbiter_if.slave  bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  typedef enum logic [1:0] {StIdle, StMemReq, StMemRel, StMstAck} state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   grant_q, grant_d;
  logic                         last_m1_q, last_m1_d;   // M1 was most recently granted
  logic                         lock_q, lock_d;
  logic                         lock_m1_q, lock_m1_d;   // lock owner: 1 = M1, 0 = M0
  logic                         mem_req_q, mem_req_d;
  logic [1:0]                   ack_q, ack_d;
  logic [LC_MEM_DATA_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;

  logic [1:0]                   req;
  logic [1:0]                   win;
  logic                         gnt_req;
  logic                         mem_write;
  logic [LC_MEM_ADDR_WIDTH-3:0] mem_addr;
  logic [LC_MEM_DATA_WIDTH-1:0] mem_wr_data;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_err_q, timeout_err_d;
`endif

  assign req     = {bus.M1_REQ, bus.M0_REQ};
  assign gnt_req = |(grant_q & req);

  // Memory-side request fields follow the current owner; zero when nobody owns the bus.
  always_comb begin
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (grant_q[1]) begin
      mem_write   = bus.M1_WRITE;
      mem_addr    = bus.M1_ADDR;
      mem_wr_data = bus.M1_WR_DATA;
    end else if (grant_q[0]) begin
      mem_write   = bus.M0_WRITE;
      mem_addr    = bus.M0_ADDR;
      mem_wr_data = bus.M0_WR_DATA;
    end
  end

  // Winner selection: a held lock excludes the other master entirely; otherwise the
  // master not most recently granted wins contention.
  always_comb begin
    win = 2'b00;
    if (lock_q) begin
      if (lock_m1_q && req[1])       win = 2'b10;
      else if (!lock_m1_q && req[0]) win = 2'b01;
    end else if (req == 2'b11) begin
      win = last_m1_q ? 2'b01 : 2'b10;
    end else begin
      win = req;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_m1_d = last_m1_q;
    lock_d    = lock_q;
    lock_m1_d = lock_m1_q;
    mem_req_d = mem_req_q;
    ack_d     = ack_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (win != 2'b00) begin
          grant_d   = win;
          last_m1_d = win[1];
          lock_d    = win[1] ? bus.M1_PEND : bus.M0_PEND;
          lock_m1_d = win[1];
          mem_req_d = 1'b1;
          state_d   = StMemReq;
`ifdef ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end

      StMemReq: begin
        if (bus.MEM_ACK_IN) begin
          mem_req_d = 1'b0;
          state_d   = StMemRel;
          if (!mem_write) begin
            if (grant_q[0]) rd0_d = bus.MEM_RD_DATA;
            if (grant_q[1]) rd1_d = bus.MEM_RD_DATA;
          end
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == TimeoutLast) begin
          // Abandon the access; the owner sees zero data and a normal ACK.
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = StMemRel;
          if (grant_q[0]) rd0_d = '0;
          if (grant_q[1]) rd1_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end

      StMemRel: begin
        if (!bus.MEM_ACK_IN) begin
          // A requester that already withdrew its REQ gets no ACK.
          if (gnt_req) ack_d = grant_q;
          state_d = StMstAck;
        end
      end

      StMstAck: begin
        if (!gnt_req) begin
          ack_d   = 2'b00;
          grant_d = 2'b00;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      last_m1_q <= 1'b1;
      lock_q    <= 1'b0;
      lock_m1_q <= 1'b0;
      mem_req_q <= 1'b0;
      ack_q     <= 2'b00;
      rd0_q     <= '0;
      rd1_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_m1_q <= last_m1_d;
      lock_q    <= lock_d;
      lock_m1_q <= lock_m1_d;
      mem_req_q <= mem_req_d;
      ack_q     <= ack_d;
      rd0_q     <= rd0_d;
      rd1_q     <= rd1_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.GRANT       = grant_q;
  assign bus.MEM_REQ_OUT = mem_req_q;
  assign bus.MEM_WRITE   = mem_write;
  assign bus.MEM_ADDR    = mem_addr;
  assign bus.MEM_WR_DATA = mem_wr_data;
  assign bus.M0_ACK      = ack_q[0];
  assign bus.M1_ACK      = ack_q[1];
  assign bus.M0_RD_DATA  = rd0_q;
  assign bus.M1_RD_DATA  = rd1_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.TIMEOUT_ERR = timeout_err_q;
`else
  assign bus.TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_lc_mem_arbiter.sv
// Directed bench for lc_mem_arbiter: reset state, single read, round-robin order, burst
// lock, early REQ withdrawal, mid-transaction reset and the memory-ack timeout.
module tb_lc_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic CLK;
  logic RESET;
  int   vectors;
  int   miscompares;

  lc_mem_arbiter_if #(.LC_MEM_DATA_WIDTH(32), .LC_MEM_ADDR_WIDTH(32)) bus ();

  lc_mem_arbiter #(
    .LC_MEM_DATA_WIDTH(32),
    .LC_MEM_ADDR_WIDTH(32),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  // Acts as the memory controller for one access and as the owning requester's release:
  // waits for MEM_REQ_OUT, acks with rdata, waits for the master ACK, then drops that
  // master's REQ. ok=0 if any bounded wait expires.
  task automatic serve(input logic [31:0] rdata, output logic [1:0] g, output bit ok);
    int n;
    ok = 1'b1;
    g  = 2'b00;
    n  = 0;
    while (bus.MEM_REQ_OUT !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.MEM_REQ_OUT !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    g = bus.GRANT;
    bus.MEM_RD_DATA = rdata;
    bus.MEM_ACK_IN  = 1'b1;
    tick();
    bus.MEM_ACK_IN  = 1'b0;
    n = 0;
    while ((bus.M0_ACK | bus.M1_ACK) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if ((bus.M0_ACK | bus.M1_ACK) !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    if (bus.M0_ACK === 1'b1) bus.M0_REQ = 1'b0;
    else                     bus.M1_REQ = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    bus.M0_ADDR = 30'h3;
    bus.M0_WRITE = 1'b1;
    apply_reset();
    vectors++;
    if ({bus.GRANT, bus.MEM_REQ_OUT, bus.M0_ACK, bus.M1_ACK} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got grant/req/ack0/ack1=%b expected 00000",
               {bus.GRANT, bus.MEM_REQ_OUT, bus.M0_ACK, bus.M1_ACK});
    end
    vectors++;
    if ({bus.M0_RD_DATA, bus.M1_RD_DATA} !== 64'h0 || bus.TIMEOUT_ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data: got rd0=%h rd1=%h terr=%b expected 0 0 0",
               bus.M0_RD_DATA, bus.M1_RD_DATA, bus.TIMEOUT_ERR);
    end
    vectors++;
    if (bus.MEM_ADDR !== 30'h0 || bus.MEM_WRITE !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_mux: got addr=%h wr=%b expected 0 0", bus.MEM_ADDR, bus.MEM_WRITE);
    end
    bus.M0_ADDR = 30'h0;
    bus.M0_WRITE = 1'b0;
  endtask

  task automatic test_read;
    apply_reset();
    bus.M0_ADDR = 30'h10;
    bus.M0_WRITE = 1'b0;
    bus.M0_REQ = 1'b1;
    #1;
    vectors++;
    if (bus.MEM_REQ_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL read_latency0: got mem_req=%b expected 0", bus.MEM_REQ_OUT);
    end
    tick();
    vectors++;
    if ({bus.MEM_REQ_OUT, bus.GRANT, bus.MEM_WRITE} !== 4'b1010 || bus.MEM_ADDR !== 30'h10) begin
      miscompares++;
      $display("FAIL read_issue: got req/grant/wr=%b addr=%h expected 1010 10",
               {bus.MEM_REQ_OUT, bus.GRANT, bus.MEM_WRITE}, bus.MEM_ADDR);
    end
    tick();
    tick();
    vectors++;
    if (bus.MEM_REQ_OUT !== 1'b1 || bus.M0_ACK !== 1'b0) begin
      miscompares++;
      $display("FAIL read_wait: got req=%b ack=%b expected 1 0", bus.MEM_REQ_OUT, bus.M0_ACK);
    end
    bus.MEM_RD_DATA = 32'hDEADBEEF;
    bus.MEM_ACK_IN = 1'b1;
    tick();
    vectors++;
    if (bus.MEM_REQ_OUT !== 1'b0 || bus.M0_RD_DATA !== 32'hDEADBEEF || bus.M0_ACK !== 1'b0) begin
      miscompares++;
      $display("FAIL read_capture: got req=%b rd0=%h ack=%b expected 0 deadbeef 0",
               bus.MEM_REQ_OUT, bus.M0_RD_DATA, bus.M0_ACK);
    end
    tick();
    vectors++;
    if (bus.M0_ACK !== 1'b0) begin
      miscompares++;
      $display("FAIL read_ack_early: got ack=%b expected 0 while MEM_ACK_IN high", bus.M0_ACK);
    end
    bus.MEM_ACK_IN = 1'b0;
    tick();
    vectors++;
    if ({bus.M0_ACK, bus.M1_ACK, bus.GRANT} !== 4'b1001 || bus.M1_RD_DATA !== 32'h0) begin
      miscompares++;
      $display("FAIL read_ack: got ack0/ack1/grant=%b rd1=%h expected 1001 0",
               {bus.M0_ACK, bus.M1_ACK, bus.GRANT}, bus.M1_RD_DATA);
    end
    bus.M0_REQ = 1'b0;
    tick();
    vectors++;
    if ({bus.M0_ACK, bus.GRANT} !== 3'b000 || bus.M0_RD_DATA !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL read_release: got ack/grant=%b rd0=%h expected 000 deadbeef",
               {bus.M0_ACK, bus.GRANT}, bus.M0_RD_DATA);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] g;
    bit ok;
    apply_reset();
    bus.M0_WRITE = 1'b0;
    bus.M1_WRITE = 1'b0;
    bus.M0_REQ = 1'b1;
    bus.M1_REQ = 1'b1;
    serve(32'hA0A0_0000, g, ok);
    vectors++;
    if (!ok || g !== 2'b01 || bus.M0_RD_DATA !== 32'hA0A0_0000) begin
      miscompares++;
      $display("FAIL rr_first: got ok=%0d grant=%b rd0=%h expected 1 01 a0a00000",
               ok, g, bus.M0_RD_DATA);
    end
    bus.M0_REQ = 1'b1;
    serve(32'hB1B1_0001, g, ok);
    vectors++;
    if (!ok || g !== 2'b10 || bus.M1_RD_DATA !== 32'hB1B1_0001) begin
      miscompares++;
      $display("FAIL rr_second: got ok=%0d grant=%b rd1=%h expected 1 10 b1b10001",
               ok, g, bus.M1_RD_DATA);
    end
    serve(32'hA2A2_0002, g, ok);
    vectors++;
    if (!ok || g !== 2'b01 || bus.M0_RD_DATA !== 32'hA2A2_0002 ||
        bus.M1_RD_DATA !== 32'hB1B1_0001) begin
      miscompares++;
      $display("FAIL rr_third: got ok=%0d grant=%b rd0=%h rd1=%h expected 1 01 a2a20002 b1b10001",
               ok, g, bus.M0_RD_DATA, bus.M1_RD_DATA);
    end
  endtask

  task automatic test_lock;
    logic [1:0] g;
    bit ok;
    apply_reset();
    bus.M1_WRITE = 1'b1;
    bus.M1_ADDR = 30'h22;
    bus.M1_WR_DATA = 32'h1234_5678;
    bus.M1_PEND = 1'b1;
    bus.M1_REQ = 1'b1;
    tick();
    bus.M0_WRITE = 1'b0;
    bus.M0_REQ = 1'b1;
    vectors++;
    if (bus.GRANT !== 2'b10 || bus.MEM_WRITE !== 1'b1 || bus.MEM_ADDR !== 30'h22 ||
        bus.MEM_WR_DATA !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL lock_write_mux: got grant=%b wr=%b addr=%h wdata=%h expected 10 1 22 12345678",
               bus.GRANT, bus.MEM_WRITE, bus.MEM_ADDR, bus.MEM_WR_DATA);
    end
    serve(32'hFFFF_0000, g, ok);
    vectors++;
    if (!ok || g !== 2'b10 || bus.M1_RD_DATA !== 32'h0) begin
      miscompares++;
      $display("FAIL lock_first: got ok=%0d grant=%b rd1=%h expected 1 10 0", ok, g, bus.M1_RD_DATA);
    end
    tick();
    tick();
    vectors++;
    if (bus.GRANT !== 2'b00 || bus.MEM_REQ_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_hold: got grant=%b req=%b expected 00 0 (M0 must wait)",
               bus.GRANT, bus.MEM_REQ_OUT);
    end
    bus.M1_PEND = 1'b0;
    bus.M1_REQ = 1'b1;
    serve(32'hFFFF_0001, g, ok);
    vectors++;
    if (!ok || g !== 2'b10) begin
      miscompares++;
      $display("FAIL lock_owner: got ok=%0d grant=%b expected 1 10", ok, g);
    end
    serve(32'h0C0C_0C0C, g, ok);
    vectors++;
    if (!ok || g !== 2'b01 || bus.M0_RD_DATA !== 32'h0C0C_0C0C) begin
      miscompares++;
      $display("FAIL lock_release: got ok=%0d grant=%b rd0=%h expected 1 01 0c0c0c0c",
               ok, g, bus.M0_RD_DATA);
    end
    bus.M1_WRITE = 1'b0;
  endtask

  task automatic test_early_drop;
    apply_reset();
    bus.M0_WRITE = 1'b0;
    bus.M0_ADDR = 30'h5;
    bus.M0_REQ = 1'b1;
    tick();
    bus.M0_REQ = 1'b0;
    tick();
    vectors++;
    if (bus.MEM_REQ_OUT !== 1'b1 || bus.GRANT !== 2'b01) begin
      miscompares++;
      $display("FAIL drop_continue: got req=%b grant=%b expected 1 01", bus.MEM_REQ_OUT, bus.GRANT);
    end
    bus.MEM_RD_DATA = 32'h0000_1234;
    bus.MEM_ACK_IN = 1'b1;
    tick();
    bus.MEM_ACK_IN = 1'b0;
    vectors++;
    if (bus.M0_RD_DATA !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL drop_capture: got rd0=%h expected 00001234", bus.M0_RD_DATA);
    end
    tick();
    vectors++;
    if (bus.M0_ACK !== 1'b0 || bus.GRANT !== 2'b01) begin
      miscompares++;
      $display("FAIL drop_noack: got ack=%b grant=%b expected 0 01", bus.M0_ACK, bus.GRANT);
    end
    tick();
    vectors++;
    if (bus.GRANT !== 2'b00 || bus.M0_ACK !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_idle: got grant=%b ack=%b expected 00 0", bus.GRANT, bus.M0_ACK);
    end
  endtask

  task automatic test_mid_reset;
    logic [1:0] g;
    bit ok;
    bus.M0_WRITE = 1'b0;
    bus.M0_REQ = 1'b1;
    tick();
    RESET = 1'b1;
    tick();
    vectors++;
    if ({bus.MEM_REQ_OUT, bus.GRANT, bus.M0_ACK, bus.M1_ACK} !== 5'b0 ||
        bus.M0_RD_DATA !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_clear: got req/grant/acks=%b rd0=%h expected 00000 0",
               {bus.MEM_REQ_OUT, bus.GRANT, bus.M0_ACK, bus.M1_ACK}, bus.M0_RD_DATA);
    end
    RESET = 1'b0;
    serve(32'h5A5A_A5A5, g, ok);
    vectors++;
    if (!ok || g !== 2'b01 || bus.M0_RD_DATA !== 32'h5A5A_A5A5) begin
      miscompares++;
      $display("FAIL midreset_resume: got ok=%0d grant=%b rd0=%h expected 1 01 5a5aa5a5",
               ok, g, bus.M0_RD_DATA);
    end
  endtask

  task automatic test_timeout;
    bus.M0_WRITE = 1'b0;
    bus.M0_REQ = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (bus.MEM_REQ_OUT !== 1'b1 || bus.TIMEOUT_ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pending: got req=%b terr=%b expected 1 0",
               bus.MEM_REQ_OUT, bus.TIMEOUT_ERR);
    end
`ifdef ARB_TIMEOUT_EN
    tick();
    vectors++;
    if (bus.MEM_REQ_OUT !== 1'b0 || bus.TIMEOUT_ERR !== 1'b1 || bus.M0_RD_DATA !== 32'h0) begin
      miscompares++;
      $display("FAIL timeout_fire: got req=%b terr=%b rd0=%h expected 0 1 0",
               bus.MEM_REQ_OUT, bus.TIMEOUT_ERR, bus.M0_RD_DATA);
    end
    tick();
    vectors++;
    if (bus.M0_ACK !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_ack: got ack=%b expected 1", bus.M0_ACK);
    end
    bus.M0_REQ = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.TIMEOUT_ERR !== 1'b1 || bus.GRANT !== 2'b00) begin
      miscompares++;
      $display("FAIL timeout_sticky: got terr=%b grant=%b expected 1 00", bus.TIMEOUT_ERR, bus.GRANT);
    end
`else
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (bus.MEM_REQ_OUT !== 1'b1 || bus.TIMEOUT_ERR !== 1'b0 || bus.M0_ACK !== 1'b0) begin
      miscompares++;
      $display("FAIL notimeout_wait: got req=%b terr=%b ack=%b expected 1 0 0",
               bus.MEM_REQ_OUT, bus.TIMEOUT_ERR, bus.M0_ACK);
    end
    begin
      logic [1:0] g;
      bit ok;
      serve(32'h7777_7777, g, ok);
      vectors++;
      if (!ok || bus.M0_RD_DATA !== 32'h7777_7777) begin
        miscompares++;
        $display("FAIL notimeout_done: got ok=%0d rd0=%h expected 1 77777777", ok, bus.M0_RD_DATA);
      end
    end
`endif
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RESET = 1'b0;
    bus.M0_REQ = 1'b0;      bus.M1_REQ = 1'b0;
    bus.M0_WRITE = 1'b0;    bus.M1_WRITE = 1'b0;
    bus.M0_ADDR = '0;       bus.M1_ADDR = '0;
    bus.M0_WR_DATA = '0;    bus.M1_WR_DATA = '0;
    bus.M0_PEND = 1'b0;     bus.M1_PEND = 1'b0;
    bus.MEM_ACK_IN = 1'b0;  bus.MEM_RD_DATA = '0;
    test_reset();
    test_read();
    test_round_robin();
    test_lock();
    test_early_drop();
    test_mid_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
